// File: rtl/cam_fb_sequencer.sv
// Purpose : rotates camera frame capture over NUM_BUFS DDR frame buffers and hands the reader the newest complete frame.
// Latency : wr_base_addr/wr_enable and rd_base_addr/rd_valid update one cycle after the wr_frame_start / rd_frame_req pulse.
// Backpres: none; pulses are consumed in the cycle they arrive and the camera master drops pixels while wr_enable = 0.
//
// Ports
//   aclk, reset          clock, synchronous active-high reset
//   init_done            fb_start_address is programmed; leaves IDLE
//   fb_start_address     DDR base of buffer 0
//   one_shot_state       1 = one-shot/hold mode, 0 = continuous capture
//   one_shot_trigger     level request for one one-shot frame (edge detected here)
//   wr_frame_start/done  SOF and end-of-frame pulses from the camera write master
//   wr_base_addr/enable  buffer base and write permission for the current camera frame
//   rd_frame_req         reader frame-start pulse
//   rd_base_addr/valid   buffer handed to the reader and whether it holds a complete frame
//   one_shot_done        pulse when a one-shot frame completes
//   frame_count          completed frames (wrapping)
//   drop_count           aborted frames (wrapping)

module cam_fb_sequencer #(
    parameter int          NUM_BUFS    = 3,
    parameter logic [31:0] FRAME_BYTES = 32'h001D_4C00,
    parameter int          CNT_WIDTH   = 16
) (
    input  logic                 aclk,
    input  logic                 reset,
    input  logic                 init_done,
    input  logic [31:0]          fb_start_address,
    input  logic                 one_shot_state,
    input  logic                 one_shot_trigger,
    input  logic                 wr_frame_start,
    input  logic                 wr_frame_done,
    output logic [31:0]          wr_base_addr,
    output logic                 wr_enable,
    input  logic                 rd_frame_req,
    output logic [31:0]          rd_base_addr,
    output logic                 rd_valid,
    output logic                 one_shot_done,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] drop_count
);

    // Two bits cover the legal 2..4 buffer range.
    localparam int IDX_W = 2;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SOF,
        S_WRITING,
        S_HOLD
    } state_t;

    state_t                 state_q, state_d;
    idx_t                   wr_idx_q, wr_idx_d;
    idx_t                   rd_idx_q, rd_idx_d;
    idx_t                   latest_idx_q, latest_idx_d;
    logic                   latest_valid_q, latest_valid_d;
    logic                   rd_valid_q, rd_valid_d;
    logic [31:0]            wr_base_q, wr_base_d;
    logic [31:0]            rd_base_q, rd_base_d;
    logic                   trig_pending_q, trig_pending_d;
    logic                   trig_in_q;
    logic                   one_shot_done_q, one_shot_done_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic                   trig_edge;
    logic                   done_commit;
    logic                   rd_take;
    idx_t                   sel_idx;

    function automatic logic [31:0] buf_base(input logic [31:0] start, input idx_t idx);
        return start + (32'(idx) * FRAME_BYTES);
    endfunction

    // Lowest buffer that is neither held by the reader nor the newest
    // complete frame. Before the reader has taken a frame it holds no
    // buffer, so rd_idx only excludes once rd_valid is set. With two
    // buffers both may be excluded; then only the reader's buffer is
    // protected and the newest frame gets overwritten.
    function automatic idx_t select_buf(input idx_t rd_i, input logic rd_v,
                                        input idx_t lat_i, input logic lat_v);
        idx_t sel;
        logic found;
        sel   = '0;
        found = 1'b0;
        for (int i = NUM_BUFS - 1; i >= 0; i--) begin
            if ((!rd_v || idx_t'(i) != rd_i) && (!lat_v || idx_t'(i) != lat_i)) begin
                sel   = idx_t'(i);
                found = 1'b1;
            end
        end
        if (!found) begin
            for (int i = NUM_BUFS - 1; i >= 0; i--) begin
                if (idx_t'(i) != rd_i) begin
                    sel = idx_t'(i);
                end
            end
        end
        return sel;
    endfunction

    assign trig_edge   = one_shot_trigger & ~trig_in_q;
    assign done_commit = (state_q == S_WRITING) && wr_frame_done;

    // Completion and read hand-off are resolved before buffer selection so
    // a same-cycle done/req/SOF combination sees consistent ownership.
    always_comb begin
        latest_idx_d   = done_commit ? wr_idx_q : latest_idx_q;
        latest_valid_d = latest_valid_q | done_commit;
        rd_take        = rd_frame_req && latest_valid_d;
        rd_idx_d       = rd_take ? latest_idx_d : rd_idx_q;
        rd_valid_d     = rd_valid_q | rd_take;
        rd_base_d      = rd_take ? buf_base(fb_start_address, latest_idx_d) : rd_base_q;
        sel_idx        = select_buf(rd_idx_d, rd_valid_d, latest_idx_d, latest_valid_d);
    end

    always_comb begin
        state_d         = state_q;
        wr_idx_d        = wr_idx_q;
        wr_base_d       = wr_base_q;
        frame_cnt_d     = frame_cnt_q;
        drop_cnt_d      = drop_cnt_q;
        one_shot_done_d = 1'b0;
        trig_pending_d  = trig_pending_q;

        case (state_q)
            S_IDLE: begin
                if (init_done) begin
                    state_d = S_WAIT_SOF;
                end
            end
            S_WAIT_SOF: begin
                if (one_shot_state) begin
                    state_d = S_HOLD;
                end else if (wr_frame_start) begin
                    wr_idx_d  = sel_idx;
                    wr_base_d = buf_base(fb_start_address, sel_idx);
                    state_d   = S_WRITING;
                end
            end
            S_WRITING: begin
                if (wr_frame_done) begin
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    if (one_shot_state) begin
                        one_shot_done_d = 1'b1;
                        state_d         = S_HOLD;
                    end else if (wr_frame_start) begin
                        // back-to-back frame: new buffer, stay writing
                        wr_idx_d  = sel_idx;
                        wr_base_d = buf_base(fb_start_address, sel_idx);
                    end else begin
                        state_d = S_WAIT_SOF;
                    end
                end else if (wr_frame_start) begin
                    // SOF before done aborts the frame; rewrite the same buffer
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                    wr_base_d  = buf_base(fb_start_address, wr_idx_q);
                end
            end
            S_HOLD: begin
                if (!one_shot_state) begin
                    trig_pending_d = 1'b0;
                    state_d        = S_WAIT_SOF;
                end else if (wr_frame_start && trig_pending_q) begin
                    trig_pending_d = 1'b0;
                    wr_idx_d       = sel_idx;
                    wr_base_d      = buf_base(fb_start_address, sel_idx);
                    state_d        = S_WRITING;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A trigger edge arms the next capture regardless of current state.
        if (trig_edge && one_shot_state) begin
            trig_pending_d = 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            wr_idx_q        <= '0;
            rd_idx_q        <= '0;
            latest_idx_q    <= '0;
            latest_valid_q  <= 1'b0;
            rd_valid_q      <= 1'b0;
            wr_base_q       <= '0;
            rd_base_q       <= '0;
            trig_pending_q  <= 1'b0;
            trig_in_q       <= 1'b0;
            one_shot_done_q <= 1'b0;
            frame_cnt_q     <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            wr_idx_q        <= wr_idx_d;
            rd_idx_q        <= rd_idx_d;
            latest_idx_q    <= latest_idx_d;
            latest_valid_q  <= latest_valid_d;
            rd_valid_q      <= rd_valid_d;
            wr_base_q       <= wr_base_d;
            rd_base_q       <= rd_base_d;
            trig_pending_q  <= trig_pending_d;
            trig_in_q       <= one_shot_trigger;
            one_shot_done_q <= one_shot_done_d;
            frame_cnt_q     <= frame_cnt_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

    assign wr_base_addr  = wr_base_q;
    assign wr_enable     = (state_q == S_WRITING);
    assign rd_base_addr  = rd_base_q;
    assign rd_valid      = rd_valid_q;
    assign one_shot_done = one_shot_done_q;
    assign frame_count   = frame_cnt_q;
    assign drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_cam_fb_sequencer.sv
// Purpose : directed checks of buffer rotation, read hand-off, drops and one-shot mode (3-buffer and 2-buffer instances).
// Latency : inputs change 1 ns after a rising edge; outputs are checked 1 ns after the edge that consumed them.
// Backpres: not applicable; every step is a fixed number of clock cycles.

module tb_cam_fb_sequencer;

    logic        aclk = 1'b0;
    logic        reset, init_done, one_shot_state, one_shot_trigger;
    logic        wr_frame_start, wr_frame_done, rd_frame_req;
    logic [31:0] fb_start_address;
    logic [31:0] wr_base_addr, rd_base_addr;
    logic        wr_enable, rd_valid, one_shot_done;
    logic [15:0] frame_count, drop_count;

    logic        reset_b, init_done_b, wr_frame_start_b, wr_frame_done_b, rd_frame_req_b;
    logic [31:0] wr_base_addr_b, rd_base_addr_b;
    logic        wr_enable_b, rd_valid_b, one_shot_done_b;
    logic [15:0] frame_count_b, drop_count_b;
    logic        osm_b, trig_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    cam_fb_sequencer #(.NUM_BUFS(3)) dut (
        .aclk(aclk), .reset(reset), .init_done(init_done),
        .fb_start_address(fb_start_address), .one_shot_state(one_shot_state),
        .one_shot_trigger(one_shot_trigger), .wr_frame_start(wr_frame_start),
        .wr_frame_done(wr_frame_done), .wr_base_addr(wr_base_addr),
        .wr_enable(wr_enable), .rd_frame_req(rd_frame_req),
        .rd_base_addr(rd_base_addr), .rd_valid(rd_valid),
        .one_shot_done(one_shot_done), .frame_count(frame_count),
        .drop_count(drop_count)
    );

    cam_fb_sequencer #(.NUM_BUFS(2)) dut_b (
        .aclk(aclk), .reset(reset_b), .init_done(init_done_b),
        .fb_start_address(fb_start_address), .one_shot_state(osm_b),
        .one_shot_trigger(trig_b), .wr_frame_start(wr_frame_start_b),
        .wr_frame_done(wr_frame_done_b), .wr_base_addr(wr_base_addr_b),
        .wr_enable(wr_enable_b), .rd_frame_req(rd_frame_req_b),
        .rd_base_addr(rd_base_addr_b), .rd_valid(rd_valid_b),
        .one_shot_done(one_shot_done_b), .frame_count(frame_count_b),
        .drop_count(drop_count_b)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; init_done = 1'b0; one_shot_state = 1'b0; one_shot_trigger = 1'b0;
        wr_frame_start = 1'b0; wr_frame_done = 1'b0; rd_frame_req = 1'b0;
        fb_start_address = 32'h1A00_0000;
        reset_b = 1'b1; init_done_b = 1'b0; wr_frame_start_b = 1'b0;
        wr_frame_done_b = 1'b0; rd_frame_req_b = 1'b0; osm_b = 1'b0; trig_b = 1'b0;
        step(2);

        chk("rst_wr_en",   32'(wr_enable), 32'd0);
        chk("rst_wr_base", wr_base_addr, 32'd0);
        chk("rst_rd_vld",  32'(rd_valid), 32'd0);
        chk("rst_rd_base", rd_base_addr, 32'd0);
        chk("rst_fc",      32'(frame_count), 32'd0);
        chk("rst_dc",      32'(drop_count), 32'd0);
        chk("rst_osd",     32'(one_shot_done), 32'd0);

        reset = 1'b0; reset_b = 1'b0; init_done = 1'b1;
        step();

        // reader asks before any frame exists
        rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
        chk("rd_before_done", 32'(rd_valid), 32'd0);

        // frame 0 -> buffer 0
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("f0_wr_en",   32'(wr_enable), 32'd1);
        chk("f0_wr_base", wr_base_addr, 32'h1A00_0000);
        step(3);
        wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
        chk("f0_fc",    32'(frame_count), 32'd1);
        chk("f0_wr_en_off", 32'(wr_enable), 32'd0);

        // reader takes buffer 0
        rd_frame_req = 1'b1; step(); rd_frame_req = 1'b0;
        chk("rd0_vld",  32'(rd_valid), 32'd1);
        chk("rd0_base", rd_base_addr, 32'h1A00_0000);

        // frame 1 -> buffer 1 (rd=0, latest=0)
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("f1_wr_base", wr_base_addr, 32'h1A1D_4C00);
        step(2);
        wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
        chk("f1_fc", 32'(frame_count), 32'd2);

        // frame 2 -> buffer 2 (rd=0, latest=1)
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("f2_wr_base", wr_base_addr, 32'h1A3A_9800);
        step(2);
        // reader request in the completing cycle gets the fresh buffer
        wr_frame_done = 1'b1; rd_frame_req = 1'b1; step();
        wr_frame_done = 1'b0; rd_frame_req = 1'b0;
        chk("rd_same_cycle_base", rd_base_addr, 32'h1A3A_9800);
        chk("f2_fc", 32'(frame_count), 32'd3);

        // frame 3 -> buffer 0 (rd=2, latest=2)
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("f3_wr_base", wr_base_addr, 32'h1A00_0000);
        fb_start_address = 32'h2000_0000; step();
        chk("fb_change_midframe", wr_base_addr, 32'h1A00_0000);
        fb_start_address = 32'h1A00_0000;

        // second SOF without done: drop, same buffer
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("drop_dc",      32'(drop_count), 32'd1);
        chk("drop_fc",      32'(frame_count), 32'd3);
        chk("drop_wr_base", wr_base_addr, 32'h1A00_0000);
        chk("drop_wr_en",   32'(wr_enable), 32'd1);

        // one-shot mode requested mid-frame: frame finishes, then hold
        one_shot_state = 1'b1; step();
        chk("os_mid_wr_en", 32'(wr_enable), 32'd1);
        wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
        chk("os_done_pulse", 32'(one_shot_done), 32'd1);
        chk("os_fc",         32'(frame_count), 32'd4);
        chk("os_hold_en",    32'(wr_enable), 32'd0);
        step();
        chk("os_done_clear", 32'(one_shot_done), 32'd0);

        // SOFs in hold without trigger are ignored
        for (int k = 0; k < 2; k++) begin
            wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
            chk("hold_sof_en", 32'(wr_enable), 32'd0);
            step();
        end

        // long trigger -> one capture into buffer 1 (rd=2, latest=0)
        one_shot_trigger = 1'b1; step(20); one_shot_trigger = 1'b0; step();
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("trig_wr_en",   32'(wr_enable), 32'd1);
        chk("trig_wr_base", wr_base_addr, 32'h1A1D_4C00);
        chk("trig_osd_low", 32'(one_shot_done), 32'd0);
        step(2);
        wr_frame_done = 1'b1; step(); wr_frame_done = 1'b0;
        chk("trig_osd",  32'(one_shot_done), 32'd1);
        chk("trig_fc",   32'(frame_count), 32'd5);
        step();
        chk("trig_osd_once", 32'(one_shot_done), 32'd0);
        chk("trig_hold_en",  32'(wr_enable), 32'd0);
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("hold_no_pending", 32'(wr_enable), 32'd0);

        // back to continuous: buffer 0 (rd=2, latest=1)
        one_shot_state = 1'b0; step();
        wr_frame_start = 1'b1; step(); wr_frame_start = 1'b0;
        chk("cont_wr_en",   32'(wr_enable), 32'd1);
        chk("cont_wr_base", wr_base_addr, 32'h1A00_0000);

        // two-buffer instance
        init_done_b = 1'b1; step();
        wr_frame_start_b = 1'b1; step(); wr_frame_start_b = 1'b0;
        chk("b_f0_base", wr_base_addr_b, 32'h1A00_0000);
        wr_frame_done_b = 1'b1; step(); wr_frame_done_b = 1'b0;
        chk("b_f0_fc", 32'(frame_count_b), 32'd1);
        rd_frame_req_b = 1'b1; step(); rd_frame_req_b = 1'b0;
        chk("b_rd_vld",  32'(rd_valid_b), 32'd1);
        chk("b_rd_base", rd_base_addr_b, 32'h1A00_0000);
        wr_frame_start_b = 1'b1; step(); wr_frame_start_b = 1'b0;
        chk("b_f1_base", wr_base_addr_b, 32'h1A1D_4C00);
        wr_frame_done_b = 1'b1; step(); wr_frame_done_b = 1'b0;
        // rd=0, latest=1: only buffer 1 is free of the reader
        wr_frame_start_b = 1'b1; step(); wr_frame_start_b = 1'b0;
        chk("b_fallback_base", wr_base_addr_b, 32'h1A1D_4C00);
        chk("b_fallback_en",   32'(wr_enable_b), 32'd1);

        // reset while writing
        reset_b = 1'b1; step();
        chk("b_rst_wr_en",   32'(wr_enable_b), 32'd0);
        chk("b_rst_wr_base", wr_base_addr_b, 32'd0);
        chk("b_rst_rd_vld",  32'(rd_valid_b), 32'd0);
        chk("b_rst_rd_base", rd_base_addr_b, 32'd0);
        chk("b_rst_fc",      32'(frame_count_b), 32'd0);
        chk("b_rst_dc",      32'(drop_count_b), 32'd0);
        chk("b_rst_osd",     32'(one_shot_done_b), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
